dual_port_sram_responder: RTL and testbench

// - Memory-side responder for the active-low SRAM interface that Top drives on KMEM/WMEM.
// - Two independent ports (1, 2), each with CSB/WEB/OEB, address, write data in and read data out.
// - Synthesizable stand-in for the kernel/weight memories: Top and the benches run without a

---
 rtl/dual_port_sram_responder.sv | 114 +++++++++++
 tb/tb_dual_port_sram_responder.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dual_port_sram_responder.sv
// Dual-port active-low SRAM responder: 2**ADDR_W x DATA_W array, RD_LAT-stage read pipeline per port,
// read-before-write semantics, port1 priority on write/write collisions flagged by COLL.
module dual_port_sram_responder #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              CSB1,
    input  logic              WEB1,
    input  logic              OEB1,
    input  logic [ADDR_W-1:0] ADD1,
    input  logic [DATA_W-1:0] DATA_I1,
    output logic [DATA_W-1:0] DATA_O1,
    output logic              RVLD1,
    input  logic              CSB2,
    input  logic              WEB2,
    input  logic              OEB2,
    input  logic [ADDR_W-1:0] ADD2,
    input  logic [DATA_W-1:0] DATA_I2,
    output logic [DATA_W-1:0] DATA_O2,
    output logic              RVLD2,
    output logic              COLL
);

    localparam int DEPTH = 2 ** ADDR_W;

    generate
        if (RD_LAT < 1 || RD_LAT > 3) begin : g_badLat
            $error("dual_port_sram_responder: RD_LAT must be 1..3");
        end
    endgenerate

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [1:0]        wrEn;
    logic [1:0]        rdEn;
    logic [ADDR_W-1:0] rdAddr [2];
    logic              coll_d;
    logic              coll_q;

    logic [RD_LAT-1:0] rdVld_q  [2];
    logic [DATA_W-1:0] rdData_q [2][RD_LAT];

    assign wrEn[0]   = ~CSB1 & ~WEB1;
    assign wrEn[1]   = ~CSB2 & ~WEB2;
    assign rdEn[0]   = ~CSB1 &  WEB1;
    assign rdEn[1]   = ~CSB2 &  WEB2;
    assign rdAddr[0] = ADD1;
    assign rdAddr[1] = ADD2;

    always_comb begin
        coll_d = 1'b0;
        if (wrEn[0] && wrEn[1] && (ADD1 == ADD2)) begin
            coll_d = 1'b1;
        end
    end

    // Port1 is written last so it wins when both ports hit the same word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (wrEn[1]) begin
                mem_q[ADD2] <= DATA_I2;
            end
            if (wrEn[0]) begin
                mem_q[ADD1] <= DATA_I1;
            end
        end
    end

    // Each data stage only loads behind a valid, so the last stage holds its word between reads.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int p = 0; p < 2; p++) begin
                rdVld_q[p] <= '0;
                for (int s = 0; s < RD_LAT; s++) begin
                    rdData_q[p][s] <= '0;
                end
            end
        end else begin
            for (int p = 0; p < 2; p++) begin
                rdVld_q[p][0] <= rdEn[p];
                if (rdEn[p]) begin
                    rdData_q[p][0] <= mem_q[rdAddr[p]];
                end
                for (int s = 1; s < RD_LAT; s++) begin
                    rdVld_q[p][s] <= rdVld_q[p][s-1];
                    if (rdVld_q[p][s-1]) begin
                        rdData_q[p][s] <= rdData_q[p][s-1];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            coll_q <= 1'b0;
        end else begin
            coll_q <= coll_d;
        end
    end

    assign RVLD1   = rdVld_q[0][RD_LAT-1];
    assign RVLD2   = rdVld_q[1][RD_LAT-1];
    assign DATA_O1 = OEB1 ? '0 : rdData_q[0][RD_LAT-1];
    assign DATA_O2 = OEB2 ? '0 : rdData_q[1][RD_LAT-1];
    assign COLL    = coll_q;

endmodule

// File: tb/tb_dual_port_sram_responder.sv
// Bench for dual_port_sram_responder: three instances (RD_LAT 1..3) share one stimulus stream
// and are compared against a plain array model of the memory.
module tb_dual_port_sram_responder;

    localparam int AW = 5;
    localparam int DW = 32;
    localparam int NI = 3;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          csb1, web1, oeb1, csb2, web2, oeb2;
    logic [AW-1:0] add1, add2;
    logic [DW-1:0] dataI1, dataI2;
    logic [DW-1:0] dout1 [NI];
    logic [DW-1:0] dout2 [NI];
    logic          rvld1 [NI];
    logic          rvld2 [NI];
    logic          coll  [NI];

    logic [DW-1:0] model [32];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    generate
        for (genvar g = 0; g < NI; g++) begin : g_dut
            dual_port_sram_responder #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(g + 1)) u_dut (
                .clk(clk), .rst_n(rst_n),
                .CSB1(csb1), .WEB1(web1), .OEB1(oeb1), .ADD1(add1), .DATA_I1(dataI1),
                .DATA_O1(dout1[g]), .RVLD1(rvld1[g]),
                .CSB2(csb2), .WEB2(web2), .OEB2(oeb2), .ADD2(add2), .DATA_I2(dataI2),
                .DATA_O2(dout2[g]), .RVLD2(rvld2[g]),
                .COLL(coll[g])
            );
        end
    endgenerate

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle;
        csb1 = 1'b1; web1 = 1'b1;
        csb2 = 1'b1; web2 = 1'b1;
    endtask

    task automatic test_reset;
        for (int cyc = 0; cyc < 4; cyc++) begin
            csb1 = 1'($urandom); web1 = 1'($urandom); oeb1 = 1'($urandom);
            csb2 = 1'($urandom); web2 = 1'($urandom); oeb2 = 1'($urandom);
            add1 = AW'($urandom); add2 = AW'($urandom);
            dataI1 = $urandom; dataI2 = $urandom;
            if (cyc == 0) begin
                rst_n = 1'b0;
                #1;
            end else begin
                tick;
            end
            for (int g = 0; g < NI; g++) begin
                checks++;
                if (dout1[g] !== '0) begin
                    errors++;
                    $display("[TB] FAIL reset dout1 lat%0d: got %h expected 0", g + 1, dout1[g]);
                end
                checks++;
                if (dout2[g] !== '0) begin
                    errors++;
                    $display("[TB] FAIL reset dout2 lat%0d: got %h expected 0", g + 1, dout2[g]);
                end
                checks++;
                if (rvld1[g] !== 1'b0 || rvld2[g] !== 1'b0) begin
                    errors++;
                    $display("[TB] FAIL reset rvld lat%0d: got %b/%b expected 0/0", g + 1, rvld1[g], rvld2[g]);
                end
                checks++;
                if (coll[g] !== 1'b0) begin
                    errors++;
                    $display("[TB] FAIL reset coll lat%0d: got %b expected 0", g + 1, coll[g]);
                end
            end
        end
        idle;
        oeb1 = 1'b0; oeb2 = 1'b0;
        rst_n = 1'b1;
        for (int i = 0; i < 32; i++) model[i] = '0;
        tick;
    endtask

    // Streams n back-to-back reads on both ports; a read issued at edge k completes after edge k+L-1.
    task automatic test_stream_reads(input int n, input int base, input int step, input bit randomAddr, input string tag);
        int            a1 [$];
        int            a2 [$];
        logic [DW-1:0] e1 [$];
        logic [DW-1:0] e2 [$];
        int            x;
        int            k;
        bit            expV;
        for (int i = 0; i < n; i++) begin
            x = randomAddr ? int'($urandom_range(0, 31)) : (base + i * step) % 32;
            a1.push_back(x);
            e1.push_back(model[x]);
            x = randomAddr ? int'($urandom_range(0, 31)) : 31 - x;
            a2.push_back(x);
            e2.push_back(model[x]);
        end
        oeb1 = 1'b0; oeb2 = 1'b0;
        for (int c = 0; c < n + NI - 1; c++) begin
            if (c < n) begin
                csb1 = 1'b0; web1 = 1'b1; add1 = AW'(a1[c]); dataI1 = $urandom;
                csb2 = 1'b0; web2 = 1'b1; add2 = AW'(a2[c]); dataI2 = $urandom;
            end else begin
                idle;
            end
            tick;
            for (int g = 0; g < NI; g++) begin
                k = c - g;
                expV = (k >= 0) && (k < n);
                checks++;
                if (rvld1[g] !== expV) begin
                    errors++;
                    $display("[TB] FAIL %s rvld1 lat%0d cyc%0d: got %b expected %b", tag, g + 1, c, rvld1[g], expV);
                end
                checks++;
                if (rvld2[g] !== expV) begin
                    errors++;
                    $display("[TB] FAIL %s rvld2 lat%0d cyc%0d: got %b expected %b", tag, g + 1, c, rvld2[g], expV);
                end
                if (expV) begin
                    checks++;
                    if (dout1[g] !== e1[k]) begin
                        errors++;
                        $display("[TB] FAIL %s dout1 lat%0d addr%0d: got %h expected %h", tag, g + 1, a1[k], dout1[g], e1[k]);
                    end
                    checks++;
                    if (dout2[g] !== e2[k]) begin
                        errors++;
                        $display("[TB] FAIL %s dout2 lat%0d addr%0d: got %h expected %h", tag, g + 1, a2[k], dout2[g], e2[k]);
                    end
                end
            end
        end
        idle;
    endtask

    task automatic test_write_read;
        oeb2 = 1'b0;
        idle;
        csb1 = 1'b0; web1 = 1'b0; add1 = 5'd5; dataI1 = 32'hDEADBEEF;
        tick;
        model[5] = 32'hDEADBEEF;
        csb1 = 1'b1;
        csb2 = 1'b0; web2 = 1'b1; add2 = 5'd5;
        for (int c = 0; c < NI; c++) begin
            tick;
            idle;
            for (int g = 0; g < NI; g++) begin
                checks++;
                if (rvld2[g] !== (c == g)) begin
                    errors++;
                    $display("[TB] FAIL write_read rvld2 lat%0d cyc%0d: got %b expected %b", g + 1, c, rvld2[g], (c == g));
                end
                if (c == g) begin
                    checks++;
                    if (dout2[g] !== 32'hDEADBEEF) begin
                        errors++;
                        $display("[TB] FAIL write_read dout2 lat%0d: got %h expected deadbeef", g + 1, dout2[g]);
                    end
                end
            end
        end
    endtask

    task automatic test_rbw;
        idle;
        csb1 = 1'b0; web1 = 1'b0; add1 = 5'd3; dataI1 = 32'h11;
        tick;
        model[3] = 32'h11;
        csb1 = 1'b0; web1 = 1'b0; add1 = 5'd3; dataI1 = 32'h22;
        csb2 = 1'b0; web2 = 1'b1; add2 = 5'd3; oeb2 = 1'b0;
        for (int c = 0; c < NI; c++) begin
            tick;
            idle;
            if (c == 0) model[3] = 32'h22;
            for (int g = 0; g < NI; g++) begin
                checks++;
                if (rvld2[g] !== (c == g)) begin
                    errors++;
                    $display("[TB] FAIL rbw rvld2 lat%0d cyc%0d: got %b expected %b", g + 1, c, rvld2[g], (c == g));
                end
                if (c == g) begin
                    checks++;
                    if (dout2[g] !== 32'h11) begin
                        errors++;
                        $display("[TB] FAIL rbw old_data lat%0d: got %h expected 00000011", g + 1, dout2[g]);
                    end
                end
            end
        end
        test_stream_reads(1, 3, 0, 1'b0, "rbw_new");
    endtask

    task automatic test_collision;
        idle;
        csb1 = 1'b0; web1 = 1'b0; add1 = 5'd31; dataI1 = 32'hAAAA0001;
        csb2 = 1'b0; web2 = 1'b0; add2 = 5'd31; dataI2 = 32'hBBBB0002;
        tick;
        idle;
        model[31] = 32'hAAAA0001;
        for (int c = 0; c < 2; c++) begin
            for (int g = 0; g < NI; g++) begin
                checks++;
                if (coll[g] !== (c == 0)) begin
                    errors++;
                    $display("[TB] FAIL collision coll lat%0d cyc%0d: got %b expected %b", g + 1, c, coll[g], (c == 0));
                end
            end
            tick;
        end
        csb1 = 1'b0; web1 = 1'b0; add1 = 5'd7; dataI1 = 32'h77770007;
        csb2 = 1'b0; web2 = 1'b0; add2 = 5'd8; dataI2 = 32'h88880008;
        tick;
        idle;
        model[7] = 32'h77770007;
        model[8] = 32'h88880008;
        for (int g = 0; g < NI; g++) begin
            checks++;
            if (coll[g] !== 1'b0) begin
                errors++;
                $display("[TB] FAIL distinct_writes coll lat%0d: got %b expected 0", g + 1, coll[g]);
            end
        end
        test_stream_reads(1, 31, 0, 1'b0, "collision_data");
        test_stream_reads(2, 7, 1, 1'b0, "distinct_data");
    endtask

    task automatic test_oeb;
        idle;
        oeb1 = 1'b1;
        csb1 = 1'b0; web1 = 1'b1; add1 = 5'd5;
        for (int c = 0; c < NI; c++) begin
            tick;
            idle;
            for (int g = 0; g < NI; g++) begin
                checks++;
                if (rvld1[g] !== (c == g)) begin
                    errors++;
                    $display("[TB] FAIL oeb rvld1 lat%0d cyc%0d: got %b expected %b", g + 1, c, rvld1[g], (c == g));
                end
                checks++;
                if (dout1[g] !== '0) begin
                    errors++;
                    $display("[TB] FAIL oeb gated dout1 lat%0d: got %h expected 0", g + 1, dout1[g]);
                end
            end
        end
        tick;
        oeb1 = 1'b0;
        #1;
        for (int g = 0; g < NI; g++) begin
            checks++;
            if (dout1[g] !== 32'hDEADBEEF) begin
                errors++;
                $display("[TB] FAIL oeb release dout1 lat%0d: got %h expected deadbeef", g + 1, dout1[g]);
            end
        end
    endtask

    task automatic test_random_traffic(input int n);
        bit expColl;
        for (int i = 0; i < n; i++) begin
            csb1 = ($urandom_range(0, 3) == 0); web1 = 1'b0;
            csb2 = ($urandom_range(0, 3) == 0); web2 = 1'b0;
            add1 = AW'($urandom); dataI1 = $urandom; dataI2 = $urandom;
            add2 = ($urandom_range(0, 3) == 0) ? add1 : AW'($urandom);
            oeb1 = 1'($urandom); oeb2 = 1'($urandom);
            expColl = !csb1 && !csb2 && (add1 == add2);
            if (!csb2) model[add2] = dataI2;
            if (!csb1) model[add1] = dataI1;
            tick;
            for (int g = 0; g < NI; g++) begin
                checks++;
                if (coll[g] !== expColl) begin
                    errors++;
                    $display("[TB] FAIL random coll lat%0d iter%0d: got %b expected %b", g + 1, i, coll[g], expColl);
                end
            end
        end
        idle;
    endtask

    task automatic test_reset_mid_read;
        idle;
        oeb1 = 1'b0; oeb2 = 1'b0;
        csb1 = 1'b0; web1 = 1'b1; add1 = 5'd5;
        csb2 = 1'b0; web2 = 1'b1; add2 = 5'd31;
        tick;
        idle;
        tick;
        rst_n = 1'b0;
        #1;
        for (int g = 0; g < NI; g++) begin
            checks++;
            if (rvld1[g] !== 1'b0 || rvld2[g] !== 1'b0) begin
                errors++;
                $display("[TB] FAIL midreset rvld lat%0d: got %b/%b expected 0/0", g + 1, rvld1[g], rvld2[g]);
            end
            checks++;
            if (dout1[g] !== '0 || dout2[g] !== '0) begin
                errors++;
                $display("[TB] FAIL midreset dout lat%0d: got %h/%h expected 0/0", g + 1, dout1[g], dout2[g]);
            end
        end
        tick;
        rst_n = 1'b1;
        for (int i = 0; i < 32; i++) model[i] = '0;
        for (int c = 0; c < 4; c++) begin
            tick;
            for (int g = 0; g < NI; g++) begin
                checks++;
                if (rvld1[g] !== 1'b0 || rvld2[g] !== 1'b0) begin
                    errors++;
                    $display("[TB] FAIL post_reset rvld lat%0d cyc%0d: got %b/%b expected 0/0", g + 1, c, rvld1[g], rvld2[g]);
                end
            end
        end
        test_stream_reads(32, 0, 1, 1'b0, "post_reset_zero");
    endtask

    initial begin
        rst_n = 1'b1;
        idle;
        oeb1 = 1'b0; oeb2 = 1'b0;
        add1 = '0; add2 = '0; dataI1 = '0; dataI2 = '0;
        #2;
        test_reset;
        test_stream_reads(32, 0, 1, 1'b0, "reset_zero");
        test_write_read;
        test_rbw;
        test_collision;
        test_oeb;
        test_random_traffic(200);
        test_stream_reads(64, 0, 0, 1'b1, "random_reads");
        test_reset_mid_read;
        $display("[TB] %0d/%0d checks passed", checks - errors, checks);
        $finish;
    end

endmodule
